// File: rtl/cfu_arbiter.sv
// cfu_arbiter: round-robin N-to-1 arbiter on the CFU req/resp handshake.
// The requester index is tagged into the downstream id and used to route responses back.
module cfu_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W = 4,
  parameter int XLEN = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        s_req_valid,
  output logic [N_REQ-1:0]        s_req_ready,
  input  logic [N_REQ*ID_W-1:0]   s_req_id,
  input  logic [N_REQ*XLEN-1:0]   s_req_data0,
  input  logic [N_REQ*XLEN-1:0]   s_req_data1,
  output logic [N_REQ-1:0]        s_resp_valid,
  input  logic [N_REQ-1:0]        s_resp_ready,
  output logic [ID_W-1:0]         s_resp_id,
  output logic [XLEN-1:0]         s_resp_data,
  output logic [2:0]              s_resp_status,
  output logic                    m_req_valid,
  input  logic                    m_req_ready,
  output logic [IDX_W+ID_W-1:0]   m_req_id,
  output logic [XLEN-1:0]         m_req_data0,
  output logic [XLEN-1:0]         m_req_data1,
  input  logic                    m_resp_valid,
  output logic                    m_resp_ready,
  input  logic [IDX_W+ID_W-1:0]   m_resp_id,
  input  logic [XLEN-1:0]         m_resp_data,
  input  logic [2:0]              m_resp_status,
  output logic                    bad_resp_err
);
  logic [IDX_W-1:0] rr_ptr, held_idx, grant, cand, resp_idx;
  logic [3:0] outstanding;
  logic lock, credit_ok, req_hs, resp_hs, resp_in_range;

  assign credit_ok = outstanding < 4'(MAX_OUTSTANDING);

  // Scan downward so the last hit is the nearest valid requester at or after rr_ptr.
  always_comb begin
    grant = rr_ptr;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (s_req_valid[cand]) grant = cand;
    end
    if (lock) grant = held_idx;
  end

  assign m_req_valid = rst_n & credit_ok & s_req_valid[grant];
  assign m_req_id = {grant, s_req_id[grant*ID_W +: ID_W]};
  assign m_req_data0 = s_req_data0[grant*XLEN +: XLEN];
  assign m_req_data1 = s_req_data1[grant*XLEN +: XLEN];
  assign s_req_ready = (rst_n & credit_ok & m_req_ready) ? N_REQ'(1) << grant : '0;
  assign req_hs = m_req_valid & m_req_ready;

  assign resp_idx = m_resp_id[ID_W +: IDX_W];
  assign resp_in_range = int'(resp_idx) < N_REQ;
  assign s_resp_valid = (rst_n & m_resp_valid & resp_in_range) ? N_REQ'(1) << resp_idx : '0;
  assign m_resp_ready = rst_n & (~resp_in_range | s_resp_ready[resp_idx]);
  assign s_resp_id = m_resp_id[ID_W-1:0];
  assign s_resp_data = m_resp_data;
  assign s_resp_status = m_resp_status;
  assign resp_hs = m_resp_valid & m_resp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      held_idx <= '0;
      lock <= 1'b0;
      outstanding <= '0;
      bad_resp_err <= 1'b0;
    end else begin
      if (req_hs) begin
        lock <= 1'b0;
        rr_ptr <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
      end else if (m_req_valid) begin
        lock <= 1'b1;
        held_idx <= grant;
      end
      if (req_hs && !resp_hs) outstanding <= outstanding + 1'b1;
      else if (resp_hs && !req_hs && outstanding != '0) outstanding <= outstanding - 1'b1;
      if (resp_hs && !resp_in_range) bad_resp_err <= 1'b1;
    end
  end
endmodule
